// File: rtl/common_scaler_pkg.sv
// Shared types for the DDA scaler: FSM states, per-cycle op encoding and a
// width helper used to size the error accumulator.
package common_scaler_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    OP_NONE     = 2'd0,
    OP_DROP     = 2'd1,
    OP_EMIT     = 2'd2,
    OP_EMIT_POP = 2'd3
  } op_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/common_scaler_dda_core.sv
// DDA accumulator: holds acc = m_idx*s_l - s_idx*m_l and decodes the op for
// the current cycle; the top decides whether that op actually commits.
module common_scaler_dda_core
  import common_scaler_pkg::*;
#(
  parameter int C_S_WIDTH   = 12,
  parameter int C_M_WIDTH   = 12,
  parameter int C_ACC_WIDTH = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_commit,
  input  logic [C_S_WIDTH-1:0] i_s_l,
  input  logic [C_M_WIDTH-1:0] i_m_l,
  input  logic                 i_m_full,
  output logic [1:0]           o_op
);

  logic [C_ACC_WIDTH-1:0] r_acc;
  logic [C_ACC_WIDTH-1:0] w_s_ext;
  logic [C_ACC_WIDTH-1:0] w_m_ext;
  logic [C_ACC_WIDTH-1:0] w_acc_plus_s;
  logic [C_ACC_WIDTH-1:0] w_acc_next;
  op_e                    w_op;

  assign w_s_ext      = C_ACC_WIDTH'(i_s_l);
  assign w_m_ext      = C_ACC_WIDTH'(i_m_l);
  // acc < m_l whenever this sum is used, so it stays below s_l+m_l and fits.
  assign w_acc_plus_s = r_acc + w_s_ext;

  always_comb begin
    w_op = OP_NONE;
    if (r_acc >= w_m_ext) begin
      w_op = OP_DROP;
    end else if (!i_m_full) begin
      w_op = (w_acc_plus_s >= w_m_ext) ? OP_EMIT_POP : OP_EMIT;
    end
  end

  always_comb begin
    w_acc_next = r_acc;
    case (w_op)
      OP_DROP:     w_acc_next = r_acc - w_m_ext;
      OP_EMIT:     w_acc_next = w_acc_plus_s;
      OP_EMIT_POP: w_acc_next = w_acc_plus_s - w_m_ext;
      default:     w_acc_next = r_acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_acc <= '0;
    end else if (i_commit) begin
      r_acc <= w_acc_next;
    end
  end

  assign o_op = w_op;

endmodule

// File: rtl/common_scaler_dda.sv
// Nearest-neighbour line scaler controller: steps s_l sources onto m_l outputs
// with a DDA, issuing pop/push strobes gated by the stream handshakes.
module common_scaler_dda
  import common_scaler_pkg::*;
#(
  parameter  int C_S_WIDTH   = 12,
  parameter  int C_M_WIDTH   = 12,
  localparam int C_ACC_WIDTH = max_int(C_S_WIDTH, C_M_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 start,
  input  logic [C_S_WIDTH-1:0] s_nbr,
  input  logic [C_M_WIDTH-1:0] m_nbr,
  input  logic                 s_valid,
  input  logic                 m_ready,
  output logic                 s_pop,
  output logic                 m_push,
  output logic                 m_first,
  output logic                 m_last,
  output logic [C_S_WIDTH-1:0] s_idx,
  output logic [C_M_WIDTH-1:0] m_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  state_e               r_state;
  logic [C_S_WIDTH-1:0] r_s_l;
  logic [C_M_WIDTH-1:0] r_m_l;
  logic [C_S_WIDTH-1:0] r_s_idx;
  logic [C_M_WIDTH-1:0] r_m_idx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_cfg_err;

  logic [1:0]           w_op_raw;
  op_e                  w_op;
  logic                 w_run;
  logic                 w_m_full;
  logic                 w_s_pop;
  logic                 w_m_push;
  logic                 w_commit;
  logic [C_S_WIDTH-1:0] w_s_idx_next;
  logic [C_M_WIDTH-1:0] w_m_idx_next;
  logic                 w_line_end;
  logic                 w_start_req;
  logic                 w_cfg_zero;
  logic                 w_start_ok;
  logic                 w_start_bad;

  assign w_run    = (r_state == RUN) && enable;
  assign w_m_full = (r_m_idx == r_m_l);
  assign w_op     = op_e'(w_op_raw);

  common_scaler_dda_core #(
    .C_S_WIDTH  (C_S_WIDTH),
    .C_M_WIDTH  (C_M_WIDTH),
    .C_ACC_WIDTH(C_ACC_WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start_ok),
    .i_commit(w_commit),
    .i_s_l   (r_s_l),
    .i_m_l   (r_m_l),
    .i_m_full(w_m_full),
    .o_op    (w_op_raw)
  );

  // A DROP needs only a source; an EMIT also needs the sink, and its
  // companion pop rides on the push so the head is never consumed early.
  always_comb begin
    w_s_pop  = 1'b0;
    w_m_push = 1'b0;
    if (w_run) begin
      case (w_op)
        OP_DROP: w_s_pop = s_valid;
        OP_EMIT: w_m_push = s_valid && m_ready;
        OP_EMIT_POP: begin
          w_m_push = s_valid && m_ready;
          w_s_pop  = s_valid && m_ready;
        end
        default: begin
          w_s_pop  = 1'b0;
          w_m_push = 1'b0;
        end
      endcase
    end
  end

  assign w_commit     = w_s_pop || w_m_push;
  assign w_s_idx_next = r_s_idx + C_S_WIDTH'(w_s_pop);
  assign w_m_idx_next = r_m_idx + C_M_WIDTH'(w_m_push);
  assign w_line_end   = (w_s_idx_next == r_s_l) && (w_m_idx_next == r_m_l);

  assign w_start_req = (r_state == IDLE) && enable && start;
  assign w_cfg_zero  = (s_nbr == '0) || (m_nbr == '0);
  assign w_start_ok  = w_start_req && !w_cfg_zero;
  assign w_start_bad = w_start_req && w_cfg_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_s_l     <= '0;
      r_m_l     <= '0;
      r_s_idx   <= '0;
      r_m_idx   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_s_l   <= s_nbr;
            r_m_l   <= m_nbr;
            r_s_idx <= '0;
            r_m_idx <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else if (w_start_bad) begin
            r_cfg_err <= 1'b1;
          end
        end
        RUN: begin
          r_s_idx <= w_s_idx_next;
          r_m_idx <= w_m_idx_next;
          // Leave on the committing cycle so done lands in the first IDLE cycle.
          if (w_commit && w_line_end) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_pop   = w_s_pop;
  assign m_push  = w_m_push;
  assign m_first = w_m_push && (r_m_idx == '0);
  assign m_last  = w_m_push && (r_m_idx == r_m_l - 1'b1);
  assign s_idx   = r_s_idx;
  assign m_idx   = r_m_idx;
  assign busy    = r_busy;
  assign done    = r_done;
  assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_common_scaler_dda.sv
// Directed bench for common_scaler_dda: table of full lines plus hand-written
// corner sequences (cycle pattern, stalls, cfg errors, back-to-back, reset).
module tb_common_scaler_dda;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        start;
  logic [11:0] s_nbr;
  logic [11:0] m_nbr;
  logic        s_valid;
  logic        m_ready;
  logic        s_pop;
  logic        m_push;
  logic        m_first;
  logic        m_last;
  logic [11:0] s_idx;
  logic [11:0] m_idx;
  logic        busy;
  logic        done;
  logic        cfg_err;

  common_scaler_dda #(.C_S_WIDTH(12), .C_M_WIDTH(12)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .start  (start),
    .s_nbr  (s_nbr),
    .m_nbr  (m_nbr),
    .s_valid(s_valid),
    .m_ready(m_ready),
    .s_pop  (s_pop),
    .m_push (m_push),
    .m_first(m_first),
    .m_last (m_last),
    .s_idx  (s_idx),
    .m_idx  (m_idx),
    .busy   (busy),
    .done   (done),
    .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s;
    int m;
    int done_cyc;
    int last_cyc;
    int drops;
  } vec_t;

  vec_t vecs[7];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Results of the most recent run_line call.
  int   res_pushes, res_pops, res_done_cyc, res_first_cyc, res_last_cyc;
  int   res_bad_src, res_idx_err, res_strobe_err, res_drops, res_push_only;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Starts a line and runs it to the done pulse; each push is checked against
  // source floor(j*s/m), and the registered indices against observed strobes.
  task automatic run_line(input int s, input int m, input bit rnd);
    int cyc;
    bit ev, sv, mr;
    res_pushes = 0; res_pops = 0; res_done_cyc = -1; res_first_cyc = -1;
    res_last_cyc = -1; res_bad_src = 0; res_idx_err = 0; res_strobe_err = 0;
    res_drops = 0; res_push_only = 0;
    @(negedge clk);
    start = 1'b1; s_nbr = 12'(s); m_nbr = 12'(m);
    enable = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (cyc = 1; cyc < 2000; cyc++) begin
      ev = 1'b1; sv = 1'b1; mr = 1'b1;
      if (rnd) begin
        ev = ($urandom_range(0, 3) != 0);
        sv = ($urandom_range(0, 2) != 0);
        mr = ($urandom_range(0, 2) != 0);
      end
      enable = ev; s_valid = sv; m_ready = mr;
      #1;
      if (done) begin
        res_done_cyc = cyc;
        break;
      end
      if (int'(s_idx) != res_pops || int'(m_idx) != res_pushes) res_idx_err++;
      if (m_push && !(ev && sv && mr)) res_strobe_err++;
      if (s_pop && !(ev && sv)) res_strobe_err++;
      if (m_push) begin
        if (res_pops != (res_pushes * s) / m) res_bad_src++;
        if (m_first) res_first_cyc = cyc;
        if (m_last) res_last_cyc = cyc;
        if (!s_pop) res_push_only++;
        res_pushes++;
      end
      if (s_pop) begin
        if (!m_push) res_drops++;
        res_pops++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int pat_push[3];
    int pat_pop[3];
    vecs[0] = '{s: 5,  m: 30, done_cyc: 31, last_cyc: 30, drops: 0};
    vecs[1] = '{s: 30, m: 5,  done_cyc: 31, last_cyc: 25, drops: 25};
    vecs[2] = '{s: 3,  m: 2,  done_cyc: 4,  last_cyc: 2,  drops: 1};
    vecs[3] = '{s: 8,  m: 8,  done_cyc: 9,  last_cyc: 8,  drops: 0};
    vecs[4] = '{s: 1,  m: 1,  done_cyc: 2,  last_cyc: 1,  drops: 0};
    vecs[5] = '{s: 7,  m: 3,  done_cyc: 8,  last_cyc: 5,  drops: 4};
    vecs[6] = '{s: 1,  m: 4,  done_cyc: 5,  last_cyc: 4,  drops: 0};
    pat_push = '{1, 1, 0};
    pat_pop  = '{1, 1, 1};

    reset = 1'b1; enable = 1'b1; start = 1'b0; s_nbr = '0; m_nbr = '0;
    s_valid = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_s_idx", s_idx, 0);
    check("reset_m_idx", m_idx, 0);
    check("reset_strobes", {s_pop, m_push}, 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_line(vecs[i].s, vecs[i].m, 1'b0);
      $display("line s=%0d m=%0d pushes=%0d pops=%0d done_cyc=%0d",
               vecs[i].s, vecs[i].m, res_pushes, res_pops, res_done_cyc);
      check($sformatf("v%0d_pushes", i), res_pushes, vecs[i].m);
      check($sformatf("v%0d_pops", i), res_pops, vecs[i].s);
      check($sformatf("v%0d_done_cyc", i), res_done_cyc, vecs[i].done_cyc);
      check($sformatf("v%0d_first_cyc", i), res_first_cyc, 1);
      check($sformatf("v%0d_last_cyc", i), res_last_cyc, vecs[i].last_cyc);
      check($sformatf("v%0d_drops", i), res_drops, vecs[i].drops);
      check($sformatf("v%0d_src_sel", i), res_bad_src, 0);
      check($sformatf("v%0d_idx_track", i), res_idx_err, 0);
      check($sformatf("v%0d_busy_end", i), busy, 0);
      check($sformatf("v%0d_s_idx_end", i), s_idx, vecs[i].s);
    end

    // Cycle-exact pattern for s=3, m=2.
    @(negedge clk);
    start = 1'b1; s_nbr = 12'd3; m_nbr = 12'd2;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      $display("s3m2 cycle %0d push=%0d pop=%0d", c + 1, m_push, s_pop);
      check($sformatf("s3m2_c%0d_push", c + 1), m_push, pat_push[c]);
      check($sformatf("s3m2_c%0d_pop", c + 1), s_pop, pat_pop[c]);
      @(negedge clk);
    end
    #1;
    check("s3m2_done_c4", done, 1);

    // Random stalls at the identity ratio.
    run_line(8, 8, 1'b1);
    $display("rand s=8 m=8 pushes=%0d pops=%0d done_cyc=%0d", res_pushes, res_pops, res_done_cyc);
    check("rand_pushes", res_pushes, 8);
    check("rand_pops", res_pops, 8);
    check("rand_push_only", res_push_only, 0);
    check("rand_idx_track", res_idx_err, 0);
    check("rand_strobe_gate", res_strobe_err, 0);
    check("rand_src_sel", res_bad_src, 0);
    check("rand_finished", (res_done_cyc > 0) ? 1 : 0, 1);
    enable = 1'b1; s_valid = 1'b1; m_ready = 1'b1;

    // Rejected starts.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; s_nbr = (k == 0) ? 12'd0 : 12'd4; m_nbr = (k == 0) ? 12'd4 : 12'd0;
      #1;
      check($sformatf("cfg%0d_idle_strobes", k), {s_pop, m_push}, 0);
      @(negedge clk);
      start = 1'b0;
      #1;
      $display("cfg start k=%0d cfg_err=%0d busy=%0d", k, cfg_err, busy);
      check($sformatf("cfg%0d_err", k), cfg_err, 1);
      check($sformatf("cfg%0d_busy", k), busy, 0);
      check($sformatf("cfg%0d_strobes", k), {s_pop, m_push}, 0);
      @(negedge clk); #1;
      check($sformatf("cfg%0d_err_clear", k), cfg_err, 0);
    end

    // Back-to-back: start accepted in the done cycle.
    run_line(2, 3, 1'b0);
    check("b2b_first_done", res_done_cyc, 4);
    start = 1'b1; s_nbr = 12'd1; m_nbr = 12'd1;
    @(negedge clk);
    start = 1'b0;
    #1;
    $display("b2b next cycle busy=%0d push=%0d pop=%0d", busy, m_push, s_pop);
    check("b2b_busy", busy, 1);
    check("b2b_push", m_push, 1);
    check("b2b_pop", s_pop, 1);
    check("b2b_first_last", {m_first, m_last}, 3);
    @(negedge clk); #1;
    check("b2b_done", done, 1);

    // Reset mid-line after 12 pushes.
    @(negedge clk);
    start = 1'b1; s_nbr = 12'd5; m_nbr = 12'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("mid_m_idx", m_idx, 12);
    check("mid_s_idx", s_idx, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    $display("after reset busy=%0d s_idx=%0d m_idx=%0d done=%0d", busy, s_idx, m_idx, done);
    check("rst_busy", busy, 0);
    check("rst_idx", {s_idx, m_idx}, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {s_pop, m_push}, 0);
    begin
      int seen_done = 0;
      repeat (4) begin
        @(negedge clk); #1;
        if (done) seen_done++;
      end
      check("rst_no_done", seen_done, 0);
    end
    run_line(5, 30, 1'b0);
    check("post_rst_pushes", res_pushes, 30);
    check("post_rst_pops", res_pops, 5);
    check("post_rst_done_cyc", res_done_cyc, 31);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/common_scaler_dda.md
Name: common_scaler_dda

Overview:
- Parametrised successor to the single-ratio scaler controller: a Bresenham/DDA stepping engine that maps one line of s_nbr source pixels onto m_nbr output pixels with nearest-neighbour selection.
- Upscales (repeat), downscales (drop) and handles the identity ratio at runtime.
- Control-only: it issues s_pop and m_push strobes. Pixel data lives in the surrounding AXI-Stream datapath.
- Sits between the source-line FIFO and the output stage of the axis_scaler.

Parameters:
- C_S_WIDTH, 12, width of s_nbr and of the source index counter.
- C_M_WIDTH, 12, width of m_nbr and of the output index counter.
- C_ACC_WIDTH, max(C_S_WIDTH,C_M_WIDTH)+1, accumulator width (derived; do not override).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global stall when low: no strobes, all state held.
- start  in  1  pulse that begins a line; honoured only in IDLE.
- s_nbr  in  C_S_WIDTH  source pixels per line; latched on an accepted start.
- m_nbr  in  C_M_WIDTH  output pixels per line; latched on an accepted start.
- s_valid  in  1  source head pixel is present.
- m_ready  in  1  output stage can accept a pixel.
- s_pop  out  1  consume the source head this cycle (combinational).
- m_push  out  1  emit the source head as an output pixel this cycle (combinational).
- m_first  out  1  m_push of output index 0.
- m_last  out  1  m_push of output index m_nbr-1.
- s_idx  out  C_S_WIDTH  registered count of sources popped this line.
- m_idx  out  C_M_WIDTH  registered count of outputs pushed this line.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at line completion.
- cfg_err  out  1  one-cycle pulse when a start is rejected.

Behaviour:
- Reset values: state IDLE; acc, s_idx, m_idx, busy, done and cfg_err all 0. Combinational strobes are 0 in IDLE.
- IDLE + start with both latched counts nonzero: latch s_l and m_l; set acc=0, s_idx=0, m_idx=0; go to RUN next cycle.
- IDLE + start with either count zero: cfg_err pulses next cycle; stay in IDLE.
- start while in RUN is ignored.
- Invariant: acc = m_idx*s_l - s_idx*m_l, always in [0, s_l+m_l).
- RUN, one decision per cycle, gated by enable:
  - DROP when acc >= m_l: s_pop = s_valid, m_push = 0. On the pop, acc -= m_l and s_idx++.
  - EMIT when acc < m_l and m_idx < m_l: m_push = s_valid & m_ready. On the push, m_idx++. The same cycle also pops (s_pop = m_push) if acc+s_l >= m_l, giving acc = acc+s_l-m_l and s_idx++. Otherwise acc += s_l.
- Once m_idx == m_l, acc = m_l*(s_l-s_idx), so DROP drains the remaining sources automatically.
- Completion: when s_idx == s_l and m_idx == m_l (acc == 0), return to IDLE and pulse done in that first IDLE cycle.
- A start is accepted in the done cycle (back-to-back lines).
- Per line: exactly s_l pops and m_l pushes. Output j uses source floor(j*s_l/m_l).
- With s_valid=m_ready=enable=1 continuously, a line takes max(s_l,m_l) RUN cycles.
- Stalls (s_valid=0, m_ready=0 during EMIT, or enable=0) hold all state; nothing is skipped.
- reset mid-line aborts immediately to IDLE with counters cleared and no done pulse.
- Arithmetic is unsigned at C_ACC_WIDTH; the subtraction happens only when acc >= m_l, so it never underflows.

Decomposition:
- Shared package common_scaler_pkg:
  - State enum: IDLE, RUN.
  - Function clog-free max() used for C_ACC_WIDTH.
  - Op encoding: OP_NONE, OP_DROP, OP_EMIT, OP_EMIT_POP.
- One sub-module, common_scaler_dda_core: holds acc and combinationally decodes the op from acc, s_l, m_l and m_idx==m_l.
- The top level holds the FSM, latches, index counters and handshake gating.

Test Plan:
- s=5, m=30, all handshakes held at 1 → 30 pushes, 5 pops; each pop coincides with every 6th push (cycles 6, 12, ..., 30); no DROP cycles; done in cycle 31; m_first in cycle 1, m_last in cycle 30.
- s=30, m=5 → 5 pushes, 30 pops in 30 cycles; pattern per output is EMIT_POP then 5×DROP; done after cycle 30.
- s=3, m=2 → cycle 1 EMIT_POP (src 0), cycle 2 EMIT_POP (src 1), cycle 3 DROP (src 2); done in cycle 4.
- s=m=8 with random s_valid/m_ready/enable → every push pops; totals 8/8; s_idx and m_idx never advance on stalled cycles.
- start with s_nbr=0 → cfg_err pulses; busy stays 0; no strobes. A start asserted in the done cycle → next line starts at the following cycle.
- reset asserted mid-line (s=5, m=30, after 12 pushes) → next cycle IDLE, s_idx=m_idx=0, no done; a fresh start then runs a full line.
